// File: rtl/mcp_trace_buffer.sv
// Instruction trace recorder for the MCP core: samples {PC, IR} once per instruction into a circular buffer,
// stops on a PC-match trigger plus post window (or a manual disarm), then reads out oldest-first.
module mcp_trace_buffer #(
    parameter int                 DATA_W        = 16,
    parameter int                 STATE_W       = 3,
    parameter logic [STATE_W-1:0] CAPTURE_STATE = 3'b001,
    parameter int                 DEPTH         = 16,
    parameter int                 POST_TRIG     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [STATE_W-1:0]     current_state,
    input  logic [DATA_W-1:0]      PC,
    input  logic [DATA_W-1:0]      IR,
    input  logic                   arm,
    input  logic                   trig_en,
    input  logic [DATA_W-1:0]      trig_pc,
    input  logic                   rd_en,
    output logic [2*DATA_W-1:0]    rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   recording,
    output logic                   triggered,
    output logic                   done,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

    state_t              state_reg;
    logic                arm_q_reg;
    logic [STATE_W-1:0]  prev_state_reg;
    logic [AW-1:0]       wr_ptr_reg;
    logic [AW-1:0]       rd_ptr_reg;
    logic [CW-1:0]       count_reg;
    logic [CW-1:0]       post_cnt_reg;
    logic                triggered_reg;
    logic                overflow_reg;
    logic                recording_reg;
    logic                done_reg;
    logic                rd_valid_reg;
    logic [2*DATA_W-1:0] rd_data_reg;

    logic [2*DATA_W-1:0] mem [DEPTH];

    logic start;
    logic cap;
    logic write_en;
    logic full;
    logic trig_hit;

    assign start    = arm & ~arm_q_reg;
    // Edge-detect the capture state so a multi-cycle fetch records only once.
    assign cap      = (current_state == CAPTURE_STATE) && (prev_state_reg != CAPTURE_STATE);
    assign write_en = cap && ((state_reg == ARMED) || (state_reg == POST));
    assign full     = (count_reg == CW'(DEPTH));
    assign trig_hit = (state_reg == ARMED) && cap && trig_en && (PC == trig_pc);

    // Storage kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_ptr_reg] <= {PC, IR};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            arm_q_reg      <= 1'b0;
            prev_state_reg <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            post_cnt_reg   <= '0;
            triggered_reg  <= 1'b0;
            overflow_reg   <= 1'b0;
            recording_reg  <= 1'b0;
            done_reg       <= 1'b0;
            rd_valid_reg   <= 1'b0;
            rd_data_reg    <= '0;
        end else begin
            arm_q_reg      <= arm;
            prev_state_reg <= current_state;
            rd_valid_reg   <= 1'b0;

            // When full, the write replaces the oldest entry, so the read side slides forward.
            if (write_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (full) begin
                    rd_ptr_reg   <= rd_ptr_reg + AW'(1);
                    overflow_reg <= 1'b1;
                end else begin
                    count_reg <= count_reg + CW'(1);
                end
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg     <= ARMED;
                        recording_reg <= 1'b1;
                        wr_ptr_reg    <= '0;
                        rd_ptr_reg    <= '0;
                        count_reg     <= '0;
                        triggered_reg <= 1'b0;
                        overflow_reg  <= 1'b0;
                    end
                end
                ARMED: begin
                    if (trig_hit) begin
                        triggered_reg <= 1'b1;
                        post_cnt_reg  <= CW'(POST_TRIG);
                        if (POST_TRIG == 0) begin
                            state_reg     <= DONE;
                            recording_reg <= 1'b0;
                            done_reg      <= 1'b1;
                        end else begin
                            state_reg <= POST;
                        end
                    end else if (!arm) begin
                        state_reg     <= DONE;
                        recording_reg <= 1'b0;
                        done_reg      <= 1'b1;
                    end
                end
                POST: begin
                    if (write_en) begin
                        post_cnt_reg <= post_cnt_reg - CW'(1);
                        if (post_cnt_reg == CW'(1)) begin
                            state_reg     <= DONE;
                            recording_reg <= 1'b0;
                            done_reg      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state_reg     <= ARMED;
                        recording_reg <= 1'b1;
                        done_reg      <= 1'b0;
                        wr_ptr_reg    <= '0;
                        rd_ptr_reg    <= '0;
                        count_reg     <= '0;
                        triggered_reg <= 1'b0;
                        overflow_reg  <= 1'b0;
                    end else if (rd_en && (count_reg != '0)) begin
                        rd_data_reg  <= mem[rd_ptr_reg];
                        rd_valid_reg <= 1'b1;
                        rd_ptr_reg   <= rd_ptr_reg + AW'(1);
                        count_reg    <= count_reg - CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;
    assign count     = count_reg;
    assign recording = recording_reg;
    assign triggered = triggered_reg;
    assign done      = done_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_mcp_trace_buffer.sv
// Bench for mcp_trace_buffer: two instances (POST_TRIG=2 and POST_TRIG=0) share stimulus and are
// compared against an instruction-level queue model.
module tb_mcp_trace_buffer;

    localparam logic [2:0] CAP   = 3'b001;
    localparam logic [2:0] OTHER = 3'b010;
    localparam int         MDEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  current_state;
    logic [15:0] PC, IR, trig_pc;
    logic        arm, trig_en, rd_en;

    logic [31:0] rd_data_w [2];
    logic        rd_valid_w [2];
    logic [3:0]  cnt_w [2];
    logic        rec_w [2];
    logic        trig_w [2];
    logic        done_w [2];
    logic        ovf_w [2];

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model: phase 0 idle, 1 armed, 2 post-trigger, 3 done.
    int          ph [2];
    int          post_left [2];
    bit          m_trig [2];
    bit          m_ovf [2];
    logic [31:0] last_rd [2];
    int          post_trig [2] = '{2, 0};
    logic [31:0] qa [$];
    logic [31:0] qb [$];

    always #5 clk = ~clk;

    mcp_trace_buffer #(.DATA_W(16), .STATE_W(3), .CAPTURE_STATE(3'b001), .DEPTH(8), .POST_TRIG(2)) dut_a (
        .clk(clk), .reset(reset), .current_state(current_state), .PC(PC), .IR(IR),
        .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc), .rd_en(rd_en),
        .rd_data(rd_data_w[0]), .rd_valid(rd_valid_w[0]), .count(cnt_w[0]),
        .recording(rec_w[0]), .triggered(trig_w[0]), .done(done_w[0]), .overflow(ovf_w[0])
    );

    mcp_trace_buffer #(.DATA_W(16), .STATE_W(3), .CAPTURE_STATE(3'b001), .DEPTH(8), .POST_TRIG(0)) dut_b (
        .clk(clk), .reset(reset), .current_state(current_state), .PC(PC), .IR(IR),
        .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc), .rd_en(rd_en),
        .rd_data(rd_data_w[1]), .rd_valid(rd_valid_w[1]), .count(cnt_w[1]),
        .recording(rec_w[1]), .triggered(trig_w[1]), .done(done_w[1]), .overflow(ovf_w[1])
    );

    function automatic int q_size(input int k);
        return (k == 0) ? qa.size() : qb.size();
    endfunction

    function automatic void q_push(input int k, input logic [31:0] v);
        if (k == 0) qa.push_back(v); else qb.push_back(v);
    endfunction

    function automatic logic [31:0] q_pop(input int k);
        return (k == 0) ? qa.pop_front() : qb.pop_front();
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            ph[k] = 0; post_left[k] = 0; m_trig[k] = 0; m_ovf[k] = 0; last_rd[k] = '0;
        end
        qa.delete();
        qb.delete();
    endfunction

    function automatic void model_start();
        for (int k = 0; k < 2; k++) begin
            if (ph[k] == 0 || ph[k] == 3) begin
                ph[k] = 1; m_trig[k] = 0; m_ovf[k] = 0;
                if (k == 0) qa.delete(); else qb.delete();
            end
        end
    endfunction

    function automatic void model_stop();
        for (int k = 0; k < 2; k++) if (ph[k] == 1) ph[k] = 3;
    endfunction

    function automatic void model_cap(input logic [15:0] pc, input logic [15:0] ir);
        logic [31:0] dropped;
        for (int k = 0; k < 2; k++) begin
            if (ph[k] == 1 || ph[k] == 2) begin
                q_push(k, {pc, ir});
                if (q_size(k) > MDEPTH) begin
                    dropped = q_pop(k);
                    m_ovf[k] = 1;
                end
                if (ph[k] == 1) begin
                    if (trig_en && pc == trig_pc) begin
                        m_trig[k] = 1;
                        post_left[k] = post_trig[k];
                        ph[k] = (post_trig[k] == 0) ? 3 : 2;
                    end
                end else begin
                    post_left[k]--;
                    if (post_left[k] == 0) ph[k] = 3;
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [15:0] pc, input logic [15:0] ir, input int hold);
        current_state = CAP;
        PC = pc;
        IR = ir;
        tick();
        model_cap(pc, ir);
        for (int k = 0; k < 2; k++) begin
            total_cnt++;
            if (cnt_w[k] !== 4'(q_size(k)) || trig_w[k] !== m_trig[k] || done_w[k] !== (ph[k] == 3) ||
                rec_w[k] !== (ph[k] == 1 || ph[k] == 2) || ovf_w[k] !== m_ovf[k])
                $display("FAIL capture dut%0d pc=%h: got cnt=%0d trig=%b done=%b rec=%b ovf=%b required cnt=%0d trig=%b done=%b rec=%b ovf=%b",
                         k, pc, cnt_w[k], trig_w[k], done_w[k], rec_w[k], ovf_w[k],
                         q_size(k), m_trig[k], ph[k] == 3, ph[k] == 1 || ph[k] == 2, m_ovf[k]);
            else pass_cnt++;
        end
        repeat (hold - 1) begin
            PC = 16'($urandom);
            tick();
        end
        current_state = OTHER;
        repeat ($urandom_range(1, 2)) tick();
    endtask

    task automatic arm_start();
        arm = 1'b1;
        tick();
        model_start();
        for (int k = 0; k < 2; k++) begin
            total_cnt++;
            if (rec_w[k] !== (ph[k] == 1 || ph[k] == 2))
                $display("FAIL arm_recording dut%0d: got %b required %b", k, rec_w[k], ph[k] == 1 || ph[k] == 2);
            else pass_cnt++;
        end
    endtask

    task automatic arm_stop();
        arm = 1'b0;
        tick();
        model_stop();
        for (int k = 0; k < 2; k++) begin
            total_cnt++;
            if (done_w[k] !== (ph[k] == 3) || cnt_w[k] !== 4'(q_size(k)))
                $display("FAIL stop dut%0d: got done=%b cnt=%0d required done=%b cnt=%0d",
                         k, done_w[k], cnt_w[k], ph[k] == 3, q_size(k));
            else pass_cnt++;
        end
    endtask

    task automatic do_reads(input int n);
        bit exp_v;
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            tick();
            for (int k = 0; k < 2; k++) begin
                exp_v = (ph[k] == 3) && (q_size(k) > 0);
                if (exp_v) last_rd[k] = q_pop(k);
                total_cnt++;
                if (rd_valid_w[k] !== exp_v || rd_data_w[k] !== last_rd[k] || cnt_w[k] !== 4'(q_size(k)))
                    $display("FAIL read%0d dut%0d: got valid=%b data=%h cnt=%0d required valid=%b data=%h cnt=%0d",
                             i, k, rd_valid_w[k], rd_data_w[k], cnt_w[k], exp_v, last_rd[k], q_size(k));
                else pass_cnt++;
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        for (int k = 0; k < 2; k++) begin
            total_cnt++;
            if (rd_data_w[k] !== 32'h0 || rd_valid_w[k] !== 1'b0 || cnt_w[k] !== 4'd0 || rec_w[k] !== 1'b0 ||
                trig_w[k] !== 1'b0 || done_w[k] !== 1'b0 || ovf_w[k] !== 1'b0)
                $display("FAIL reset dut%0d: got data=%h v=%b cnt=%0d rec=%b trig=%b done=%b ovf=%b required all zero",
                         k, rd_data_w[k], rd_valid_w[k], cnt_w[k], rec_w[k], trig_w[k], done_w[k], ovf_w[k]);
            else pass_cnt++;
        end
        reset = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_basic_fill();
        trig_en = 1'b0;
        arm_start();
        for (int i = 0; i < 5; i++) run_instr(16'(2 * i), 16'($urandom), $urandom_range(1, 3));
        arm_stop();
        total_cnt++;
        if (done_w[0] !== 1'b1 || cnt_w[0] !== 4'd5 || ovf_w[0] !== 1'b0)
            $display("FAIL basic_fill: got done=%b cnt=%0d ovf=%b required done=1 cnt=5 ovf=0", done_w[0], cnt_w[0], ovf_w[0]);
        else pass_cnt++;
        do_reads(6);
    endtask

    task automatic test_wrap_overflow();
        trig_en = 1'b0;
        arm_start();
        for (int i = 1; i <= 11; i++) run_instr(16'(16'h0100 + 2 * i), 16'($urandom), $urandom_range(1, 2));
        arm_stop();
        total_cnt++;
        if (cnt_w[0] !== 4'd8 || ovf_w[0] !== 1'b1)
            $display("FAIL wrap_overflow: got cnt=%0d ovf=%b required cnt=8 ovf=1", cnt_w[0], ovf_w[0]);
        else pass_cnt++;
        do_reads(9);
    endtask

    task automatic test_trigger();
        trig_en = 1'b1;
        trig_pc = 16'h0006;
        arm_start();
        for (int i = 0; i < 8; i++) run_instr(16'(2 * i), 16'($urandom), $urandom_range(1, 3));
        total_cnt++;
        if (cnt_w[0] !== 4'd6 || cnt_w[1] !== 4'd4 || trig_w[0] !== 1'b1 || trig_w[1] !== 1'b1)
            $display("FAIL trigger_window: got cnt_a=%0d cnt_b=%0d trig_a=%b trig_b=%b required 6 4 1 1",
                     cnt_w[0], cnt_w[1], trig_w[0], trig_w[1]);
        else pass_cnt++;
        arm = 1'b0;
        tick();
        model_stop();
        do_reads(7);
        total_cnt++;
        if (rd_data_w[0][31:16] !== 16'h000a || rd_data_w[1][31:16] !== 16'h0006)
            $display("FAIL trigger_last_pc: got a=%h b=%h required a=000a b=0006", rd_data_w[0][31:16], rd_data_w[1][31:16]);
        else pass_cnt++;
        trig_en = 1'b0;
    endtask

    task automatic test_multicycle();
        trig_en = 1'b0;
        arm_start();
        run_instr(16'h0040, 16'($urandom), 3);
        total_cnt++;
        if (cnt_w[0] !== 4'd1)
            $display("FAIL multicycle: got cnt=%0d required 1", cnt_w[0]);
        else pass_cnt++;
        arm_stop();
        do_reads(2);
    endtask

    task automatic test_reset_mid();
        trig_en = 1'b1;
        trig_pc = 16'h0010;
        arm_start();
        run_instr(16'h000c, 16'($urandom), 1);
        run_instr(16'h000e, 16'($urandom), 1);
        run_instr(16'h0010, 16'($urandom), 1);
        run_instr(16'h0012, 16'($urandom), 1);
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            total_cnt++;
            if (rd_valid_w[k] !== 1'b0 || cnt_w[k] !== 4'd0 || rec_w[k] !== 1'b0 || trig_w[k] !== 1'b0 ||
                done_w[k] !== 1'b0 || ovf_w[k] !== 1'b0 || rd_data_w[k] !== 32'h0)
                $display("FAIL reset_in_post dut%0d: got cnt=%0d rec=%b trig=%b done=%b required all zero",
                         k, cnt_w[k], rec_w[k], trig_w[k], done_w[k]);
            else pass_cnt++;
        end
        model_reset();
        arm = 1'b0;
        trig_en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        arm_start();
        for (int i = 0; i < 3; i++) run_instr(16'(16'h0200 + 2 * i), 16'($urandom), 1);
        arm_stop();
        total_cnt++;
        if (cnt_w[0] !== 4'd3 || ovf_w[0] !== 1'b0)
            $display("FAIL rearm_after_reset: got cnt=%0d ovf=%b required cnt=3 ovf=0", cnt_w[0], ovf_w[0]);
        else pass_cnt++;
        do_reads(1);
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            total_cnt++;
            if (rd_valid_w[k] !== 1'b0 || rd_data_w[k] !== 32'h0 || cnt_w[k] !== 4'd0 || done_w[k] !== 1'b0)
                $display("FAIL reset_in_readout dut%0d: got v=%b data=%h cnt=%0d done=%b required 0 0 0 0",
                         k, rd_valid_w[k], rd_data_w[k], cnt_w[k], done_w[k]);
            else pass_cnt++;
        end
        model_reset();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 8; it++) begin
            trig_en = 1'($urandom_range(0, 1));
            trig_pc = 16'(2 * $urandom_range(0, 7));
            arm = 1'b0;
            tick();
            model_stop();
            arm_start();
            n = $urandom_range(2, 14);
            for (int i = 0; i < n; i++)
                run_instr(16'(2 * $urandom_range(0, 7)), 16'($urandom), $urandom_range(1, 3));
            arm_stop();
            do_reads($urandom_range(0, 10));
        end
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; trig_en = 1'b0; rd_en = 1'b0;
        current_state = 3'b000; PC = '0; IR = '0; trig_pc = '0;
        model_reset();
        test_reset();
        test_basic_fill();
        test_wrap_overflow();
        test_trigger();
        test_multicycle();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/mcp_trace_buffer.md
# mcp_trace_buffer

Parametrised on-chip instruction trace recorder for the multi-cycle processor (MCP). It samples `{PC, IR}` once per instruction, when the core's state register enters a configurable capture state, into a circular buffer of depth `DEPTH`. It supports a PC-match trigger with a post-trigger window, or a manual stop. After stopping, the buffer is frozen and read out oldest-first over a simple read handshake. It sits beside the MCP core and taps `current_state`, `PC` and `IR` without affecting execution.

## Interface
Parameters:
- `DATA_W`, 16: width of `PC` and `IR`.
- `STATE_W`, 3: width of the core state code.
- `CAPTURE_STATE`, 3'b001: state code in which `IR` holds the newly fetched instruction.
- `DEPTH`, 16: entries; power of two, ≥ 4.
- `POST_TRIG`, 4: captures recorded after the trigger entry; must be < `DEPTH`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `current_state`, in, `STATE_W`: core FSM state.
- `PC`, in, `DATA_W`: core program counter.
- `IR`, in, `DATA_W`: core instruction register.
- `arm`, in, 1: a rising edge starts a new recording.
- `trig_en`, in, 1: enables the PC-match trigger.
- `trig_pc`, in, `DATA_W`: trigger address.
- `rd_en`, in, 1: pops the oldest entry (honoured in DONE only).
- `rd_data`, out, `2*DATA_W`: `{PC, IR}` of the popped entry.
- `rd_valid`, out, 1: one-cycle strobe qualifying `rd_data`.
- `count`, out, `$clog2(DEPTH)+1`: number of valid entries.
- `recording`, out, 1: high in ARMED or POST.
- `triggered`, out, 1: a trigger match has occurred this recording.
- `done`, out, 1: high in DONE.
- `overflow`, out, 1: at least one entry has been overwritten this recording.

## Operation
- State machine with four states: IDLE, ARMED, POST, DONE.
- `arm_q` is a registered copy of `arm`. `start = arm & ~arm_q`.
- **Capture event.** `cap = (current_state == CAPTURE_STATE) && (prev_state != CAPTURE_STATE)`, where `prev_state` is registered. A capture therefore occurs once per instruction, even when the core sits in the capture state for several cycles.
- **IDLE.** `start` → ARMED. The wr/rd pointers, `count`, `triggered` and `overflow` are cleared.
- **ARMED.**
  - On `cap`, write `{PC, IR}` at `wr_ptr`, increment `wr_ptr` (wraps modulo `DEPTH`) and increment `count`, saturating at `DEPTH`.
  - If `count == DEPTH` at the write, the oldest entry is overwritten: `rd_ptr` advances and `overflow` is set.
  - If `trig_en` is high and the captured `PC == trig_pc`:
    - set `triggered` and load `post_cnt = POST_TRIG`;
    - if `POST_TRIG == 0` → DONE, otherwise → POST.
  - `arm` low with no trigger → DONE (manual stop). A `cap` in the same cycle is still written.
- **POST.** Each `cap` is written as in ARMED, with no further trigger matching, and `post_cnt` decrements. When a capture brings `post_cnt` from 1 to 0 → DONE. `arm` low has no effect in POST.
- **DONE.**
  - Captures are ignored.
  - `rd_en` with `count != 0` registers `mem[rd_ptr]` into `rd_data`, pulses `rd_valid`, increments `rd_ptr` (wrap) and decrements `count`.
  - `rd_en` with `count == 0` is ignored: `rd_valid` stays 0 and `rd_data` holds its value.
  - `start` → ARMED with a full clear. Unread entries are discarded.
- `start` while in ARMED or POST is ignored.
- **Reset.** An asynchronous `reset` in any state, including mid-recording or mid-readout, returns to IDLE. `arm_q` and `prev_state` reset to 0. Memory contents need not be cleared.

## Timing
- Reset values: `rd_data = 0`, `rd_valid = 0`, `count = 0`, `recording = 0`, `triggered = 0`, `done = 0`, `overflow = 0`.
- `recording` rises on the clock edge after the cycle in which `arm` is first seen high.
- A capture is reflected in `count` on the edge that samples `cap`, i.e. visible one cycle after the qualifying cycle.
- `triggered`, and the ARMED→POST/DONE transition, update on the same edge as the trigger capture.
- `done` rises on the edge of the final post-trigger capture, or on the edge that samples `arm` low in ARMED.
- Read latency is 1 cycle: `rd_en` in cycle n gives `rd_valid` and `rd_data` in cycle n+1.
- Back-to-back `rd_en` gives one entry per cycle.
- `overflow` is sticky until the next `start` or `reset`.

## Test plan
- **Basic fill.** `DEPTH=8`, `POST_TRIG=2`, `trig_en=0`. Arm, let the core run 5 instructions, drop `arm` → `done=1`, `count=5`, `overflow=0`. Issue 5 reads → PCs in program order; a 6th `rd_en` gives no `rd_valid`.
- **Wrap and overflow.** As above, but run 11 instructions before stopping → `count=8`, `overflow=1`. Reads return instructions 4..11 oldest-first.
- **Trigger window.** `trig_en=1`, `trig_pc=16'h0006`, sequential PCs 0,2,4,…. Arm → `triggered` set at the PC 6 capture; `done` set after the captures of PCs 8 and 10. Readout ends at PC 10 and PC 12 is never recorded.
- **`POST_TRIG=0`.** A trigger capture goes straight to DONE; the last entry read is the trigger PC.
- **Multi-cycle capture state.** Hold `current_state = CAPTURE_STATE` for 3 cycles → exactly 1 entry recorded.
- **Reset mid-operation.** Assert `reset` during POST, then during readout → all outputs 0 in the same cycle (async). A new `arm` edge records from empty.
